triangle_scan_ctrl: RTL and testbench
=====================================

# triangle_scan_ctrl

Sequencer that rasterizes one triangle through the existing `checkPoint` point-in-triangle datapath. It accepts three vertices with a start/ready handshake and computes their bounding box. It then sweeps every integer point of the box, one per cycle, into `checkPoint` and collects the returned `check` bits. It emits a stream of inside points and a final inside count, and sits between a geometry source and any consumer of covered pixels.

## Interface
- `W`, 11, coordinate width (unsigned, 0..2^W-1).
- `CHECK_LAT`, 1, cycles from a point on `px/py` to its `check` result (0 = combinational `checkPoint`).
- `CNT_W`, 2*W+1, width of `inside_count`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request to scan; accepted only when `start && ready`.
- `ax, ay, bx, by, cx, cy`  in  W each  vertices; sampled only on accept.
- `ready`  out  1  high in IDLE only.
- `px, py`  out  W each  point driven to `checkPoint`.
- `pt_valid`  out  1  `px/py` carry a scan point this cycle.
- `check`  in  1  `checkPoint` result for the point presented CHECK_LAT cycles earlier.
- `hit_valid`  out  1  registered; `hit_x/hit_y` is an inside point.
- `hit_x, hit_y`  out  W each  inside point coordinates.
- `done`  out  1  one-cycle pulse when the scan is complete and the count is final.
- `inside_count`  out  CNT_W  number of inside points of the last or current scan.

## Operation
- States: IDLE -> BBOX -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE: `ready`=1. On `start`, latch all six vertices and go to BBOX. Later vertex input changes are ignored.
- BBOX (1 cycle): register xmin/xmax/ymin/ymax as min/max of the three latched x and y values; clear `inside_count`; go to SCAN.
- SCAN: `pt_valid`=1 every cycle. Order is raster: x inner loop xmin..xmax, y outer loop ymin..ymax, box edges inclusive. Termination compares for equality with xmax/ymax before incrementing, so coordinates never wrap, even at 2^W-1. After presenting (xmax,ymax), go to DRAIN, or to DONE if CHECK_LAT=0.
- Result path: `pt_valid`/`px`/`py` travel through a CHECK_LAT-deep delay line. When the delayed valid and `check` are both 1, on the next edge: `hit_valid`=1, `hit_x/hit_y` = delayed coordinates, and `inside_count` increments by 1. Otherwise `hit_valid`=0.
- DRAIN: stay exactly CHECK_LAT cycles with `pt_valid`=0, then go to DONE.
- DONE (1 cycle): `done`=1, `ready`=0; go to IDLE.
- `inside_count` holds its final value until the BBOX cycle of the next accepted scan.
- `start` outside IDLE is ignored. No queuing.
- Degenerate triangles (collinear or all vertices equal) are scanned normally. Coverage is decided only by `check`.
- Reset values, applied at any time including mid-scan: state IDLE, `ready`=1 from the first cycle after reset, `pt_valid`=0, `hit_valid`=0, `done`=0, `px`=`py`=`hit_x`=`hit_y`=0, `inside_count`=0, delay line flushed. Results still in flight are discarded.

## Timing
- Accept edge at the end of cycle 0. Cycle 1 is BBOX. The first `pt_valid` is in cycle 2.
- N = (xmax-xmin+1)*(ymax-ymin+1). `pt_valid` is high for cycles 2..N+1, contiguous with no bubbles.
- A point presented in cycle t has `check` sampled in cycle t+CHECK_LAT. Its hit, if any, appears in cycle t+CHECK_LAT+1.
- `done` is in cycle N+2+CHECK_LAT. In that cycle the last hit (if any) and the final `inside_count` are visible.
- `ready` is 1 again in cycle N+3+CHECK_LAT. Back-to-back scans therefore have 3+CHECK_LAT idle/overhead cycles between them.
- Throughput: 1 point/cycle during SCAN.

## Test plan
Bench drives `check` from a golden edge-inclusive model delayed by CHECK_LAT. Default parameters unless noted.
- Vertices (0,0),(4,0),(0,4): 25 `pt_valid` cycles in raster order; 15 hits, all with x+y<=4; `done` in cycle 28; `inside_count`=15.
- All vertices (7,7): 1 point; `hit_valid` with (7,7) in cycle 4 alongside `done`; `inside_count`=1.
- Vertices (2045,2047),(2047,2047),(2047,2045): 9 points; `px/py` never exceed 2047; 6 hits; `inside_count`=6.
- `check` forced 0, triangle (0,0),(4,0),(0,4): `hit_valid` never asserts; `done` still in cycle 28; `inside_count`=0.
- `start` pulsed during SCAN with different vertices: ignored, first scan results unchanged. Then `rst` for 1 cycle mid-scan: next cycle IDLE, all outputs at reset values, a new scan completes correctly.
- CHECK_LAT=0 and CHECK_LAT=3 with triangle (0,0),(4,0),(0,4): `done` in cycles 27 and 30 respectively, `inside_count`=15 in both.

Source files
------------

// File: rtl/triangle_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : triangle_scan_ctrl
//  Purpose  : Bounding-box raster sequencer feeding a checkPoint datapath;
//             collects inside points and an inside count for one triangle.
//  Revision : 1.0  initial release
// ============================================================================
module triangle_scan_ctrl #(
  parameter int W         = 11,
  parameter int CHECK_LAT = 1,
  parameter int CNT_W     = 2*W+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     ax,
  input  logic [W-1:0]     ay,
  input  logic [W-1:0]     bx,
  input  logic [W-1:0]     by,
  input  logic [W-1:0]     cx,
  input  logic [W-1:0]     cy,
  output logic             ready,
  output logic [W-1:0]     px,
  output logic [W-1:0]     py,
  output logic             pt_valid,
  input  logic             check,
  output logic             hit_valid,
  output logic [W-1:0]     hit_x,
  output logic [W-1:0]     hit_y,
  output logic             done,
  output logic [CNT_W-1:0] inside_count
);

  localparam int c_DRAIN_W = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BBOX  = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W-1:0] r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
  logic [W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic [c_DRAIN_W-1:0] r_drain;
  logic         w_x_last, w_y_last;
  logic         w_dv;
  logic [W-1:0] w_dx, w_dy;

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  assign w_xmin = min3(r_ax, r_bx, r_cx);
  assign w_xmax = max3(r_ax, r_bx, r_cx);
  assign w_ymin = min3(r_ay, r_by, r_cy);
  assign w_ymax = max3(r_ay, r_by, r_cy);

  // Equality against the box edge, so the counters never wrap at 2^W-1.
  assign w_x_last = (px == r_xmax);
  assign w_y_last = (py == r_ymax);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    ready    = 1'b0;
    pt_valid = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_next = S_BBOX;
      end
      S_BBOX: w_next = S_SCAN;
      S_SCAN: begin
        pt_valid = 1'b1;
        if (w_x_last && w_y_last) w_next = (CHECK_LAT == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain == c_DRAIN_W'(CHECK_LAT-1)) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ax    <= '0;
      r_ay    <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymin  <= '0;
      r_ymax  <= '0;
      px      <= '0;
      py      <= '0;
      r_drain <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_ax <= ax;
        r_ay <= ay;
        r_bx <= bx;
        r_by <= by;
        r_cx <= cx;
        r_cy <= cy;
      end
      if (r_state == S_BBOX) begin
        r_xmin <= w_xmin;
        r_xmax <= w_xmax;
        r_ymin <= w_ymin;
        r_ymax <= w_ymax;
        px     <= w_xmin;
        py     <= w_ymin;
      end
      if (r_state == S_SCAN) begin
        if (!w_x_last) begin
          px <= px + 1'b1;
        end else if (!w_y_last) begin
          px <= r_xmin;
          py <= py + 1'b1;
        end
      end
      if (r_state == S_DRAIN) begin
        r_drain <= r_drain + 1'b1;
      end else begin
        r_drain <= '0;
      end
    end
  end

  generate
    if (CHECK_LAT == 0) begin : g_lat0
      assign w_dv = pt_valid;
      assign w_dx = px;
      assign w_dy = py;
    end else begin : g_latn
      logic [CHECK_LAT-1:0] r_dv;
      logic [W-1:0]         r_dx [CHECK_LAT];
      logic [W-1:0]         r_dy [CHECK_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_dv <= '0;
          for (int i = 0; i < CHECK_LAT; i++) begin
            r_dx[i] <= '0;
            r_dy[i] <= '0;
          end
        end else begin
          r_dv[0] <= pt_valid;
          r_dx[0] <= px;
          r_dy[0] <= py;
          for (int i = 1; i < CHECK_LAT; i++) begin
            r_dv[i] <= r_dv[i-1];
            r_dx[i] <= r_dx[i-1];
            r_dy[i] <= r_dy[i-1];
          end
        end
      end

      assign w_dv = r_dv[CHECK_LAT-1];
      assign w_dx = r_dx[CHECK_LAT-1];
      assign w_dy = r_dy[CHECK_LAT-1];
    end
  endgenerate

  // Hits can never overlap BBOX: a new scan only starts after DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_valid    <= 1'b0;
      hit_x        <= '0;
      hit_y        <= '0;
      inside_count <= '0;
    end else begin
      hit_valid <= w_dv & check;
      if (w_dv && check) begin
        hit_x        <= w_dx;
        hit_y        <= w_dy;
        inside_count <= inside_count + 1'b1;
      end else if (r_state == S_BBOX) begin
        inside_count <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_triangle_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_triangle_scan_ctrl
//  Purpose  : Scoreboard bench for triangle_scan_ctrl at CHECK_LAT 1, 0 and 3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_triangle_scan_ctrl;
  localparam int W  = 11;
  localparam int CW = 2*W+1;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] start_v;
  logic [W-1:0] ax, ay, bx, by, cx, cy;

  // index 0: CHECK_LAT=1, index 1: CHECK_LAT=0, index 2: CHECK_LAT=3
  logic          ready_a, ready_b, ready_c;
  logic [W-1:0]  px_a, py_a, px_b, py_b, px_c, py_c;
  logic          pv_a, pv_b, pv_c;
  logic          check_a, check_b, check_c;
  logic          hv_a, hv_b, hv_c;
  logic [W-1:0]  hx_a, hy_a, hx_b, hy_b, hx_c, hy_c;
  logic          done_a, done_b, done_c;
  logic [CW-1:0] cnt_a, cnt_b, cnt_c;

  triangle_scan_ctrl #(.W(W), .CHECK_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .ready(ready_a), .px(px_a), .py(py_a), .pt_valid(pv_a), .check(check_a),
    .hit_valid(hv_a), .hit_x(hx_a), .hit_y(hy_a), .done(done_a), .inside_count(cnt_a));

  triangle_scan_ctrl #(.W(W), .CHECK_LAT(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .ready(ready_b), .px(px_b), .py(py_b), .pt_valid(pv_b), .check(check_b),
    .hit_valid(hv_b), .hit_x(hx_b), .hit_y(hy_b), .done(done_b), .inside_count(cnt_b));

  triangle_scan_ctrl #(.W(W), .CHECK_LAT(3)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .ready(ready_c), .px(px_c), .py(py_c), .pt_valid(pv_c), .check(check_c),
    .hit_valid(hv_c), .hit_x(hx_c), .hit_y(hy_c), .done(done_c), .inside_count(cnt_c));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Golden edge-inclusive point-in-triangle model for the active scan.
  int tv[6];
  bit f0 = 1'b0;

  function automatic bit golden(input int x, input int y);
    longint e1, e2, e3;
    e1 = longint'(tv[2]-tv[0])*(y-tv[1]) - longint'(tv[3]-tv[1])*(x-tv[0]);
    e2 = longint'(tv[4]-tv[2])*(y-tv[3]) - longint'(tv[5]-tv[3])*(x-tv[2]);
    e3 = longint'(tv[0]-tv[4])*(y-tv[5]) - longint'(tv[1]-tv[5])*(x-tv[4]);
    return !f0 && ((e1 >= 0 && e2 >= 0 && e3 >= 0) || (e1 <= 0 && e2 <= 0 && e3 <= 0));
  endfunction

  logic         d1v;
  logic [W-1:0] d1x, d1y;
  logic [2:0]   d3v;
  logic [W-1:0] d3x [3];
  logic [W-1:0] d3y [3];

  always @(posedge clk) begin
    d1v <= pv_a;
    d1x <= px_a;
    d1y <= py_a;
    d3v <= {d3v[1:0], pv_c};
    d3x[0] <= px_c; d3x[1] <= d3x[0]; d3x[2] <= d3x[1];
    d3y[0] <= py_c; d3y[1] <= d3y[0]; d3y[2] <= d3y[1];
  end

  assign check_a = d1v    && golden(int'(d1x), int'(d1y));
  assign check_b = pv_b   && golden(int'(px_b), int'(py_b));
  assign check_c = d3v[2] && golden(int'(d3x[2]), int'(d3y[2]));

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } pt_t;

  pt_t pq[$];
  pt_t hq[$];
  pt_t e_pt, e_hit;

  int  c0;
  int  pv_cnt, hv_cnt, last_hit_cyc;
  bit  [2:0] done_seen;
  int  done_cyc [3];
  logic [CW-1:0] done_cnt [3];
  int  lat_of [3] = '{1, 0, 3};

  always @(negedge clk) begin
    if (pv_a) begin
      pv_cnt++;
      if (pq.size() == 0) chk("pt_extra", 64'(pv_a), 64'd0);
      else begin
        e_pt = pq.pop_front();
        chk("px", 64'(px_a), 64'(e_pt.x));
        chk("py", 64'(py_a), 64'(e_pt.y));
      end
    end
    if (hv_a) begin
      hv_cnt++;
      last_hit_cyc = cyc;
      if (hq.size() == 0) chk("hit_extra", 64'(hv_a), 64'd0);
      else begin
        e_hit = hq.pop_front();
        chk("hit_x", 64'(hx_a), 64'(e_hit.x));
        chk("hit_y", 64'(hy_a), 64'(e_hit.y));
      end
    end
    if (done_a) begin done_seen[0] = 1'b1; done_cyc[0] = cyc; done_cnt[0] = cnt_a; end
    if (done_b) begin done_seen[1] = 1'b1; done_cyc[1] = cyc; done_cnt[1] = cnt_b; end
    if (done_c) begin done_seen[2] = 1'b1; done_cyc[2] = cyc; done_cnt[2] = cnt_c; end
  end

  task automatic launch(input int v0, v1, v2, v3, v4, v5, input bit force0, input bit [2:0] sel);
    int xmin, xmax, ymin, ymax;
    @(posedge clk); #1;
    tv = '{v0, v1, v2, v3, v4, v5};
    f0 = force0;
    ax = 11'(v0); ay = 11'(v1); bx = 11'(v2); by = 11'(v3); cx = 11'(v4); cy = 11'(v5);
    xmin = (v0 < v2) ? v0 : v2; xmin = (xmin < v4) ? xmin : v4;
    xmax = (v0 > v2) ? v0 : v2; xmax = (xmax > v4) ? xmax : v4;
    ymin = (v1 < v3) ? v1 : v3; ymin = (ymin < v5) ? ymin : v5;
    ymax = (v1 > v3) ? v1 : v3; ymax = (ymax > v5) ? ymax : v5;
    if (sel[0]) begin
      for (int y = ymin; y <= ymax; y++)
        for (int x = xmin; x <= xmax; x++) begin
          pq.push_back('{x: 11'(x), y: 11'(y)});
          if (golden(x, y)) hq.push_back('{x: 11'(x), y: 11'(y)});
        end
    end
    pv_cnt = 0;
    hv_cnt = 0;
    last_hit_cyc = -1;
    done_seen = '0;
    c0 = cyc;
    start_v = sel;
    @(posedge clk); #1;
    start_v = '0;
  endtask

  task automatic wait_done(input bit [2:0] sel, input string tag, input int n, input int cnt);
    for (int i = 0; i < 400 && (done_seen & sel) != sel; i++) @(posedge clk);
    #1;
    chk({tag, "_done_seen"}, 64'(done_seen & sel), 64'(sel));
    for (int k = 0; k < 3; k++) begin
      if (sel[k]) begin
        chk({tag, "_done_cycle"}, 64'(done_cyc[k] - c0), 64'(n + 2 + lat_of[k]));
        chk({tag, "_count"}, 64'(done_cnt[k]), 64'(cnt));
      end
    end
    if (sel[0]) begin
      chk({tag, "_ready_after"}, 64'(ready_a), 64'd1);
      chk({tag, "_count_hold"}, 64'(cnt_a), 64'(cnt));
      chk({tag, "_npts"}, 64'(pv_cnt), 64'(n));
      chk({tag, "_nhits"}, 64'(hv_cnt), 64'(cnt));
      chk({tag, "_pts_left"}, 64'(pq.size()), 64'd0);
      chk({tag, "_hits_left"}, 64'(hq.size()), 64'd0);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, 64'(ready_a), 64'd1);
    chk({tag, "_pt_valid"}, 64'(pv_a), 64'd0);
    chk({tag, "_hit_valid"}, 64'(hv_a), 64'd0);
    chk({tag, "_done"}, 64'(done_a), 64'd0);
    chk({tag, "_pxy"}, 64'({px_a, py_a}), 64'd0);
    chk({tag, "_hxy"}, 64'({hx_a, hy_a}), 64'd0);
    chk({tag, "_count"}, 64'(cnt_a), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_v = '0;
    {ax, ay, bx, by, cx, cy} = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("rst0");

    launch(0, 0, 4, 0, 0, 4, 1'b0, 3'b001);
    wait_done(3'b001, "tri", 25, 15);

    launch(7, 7, 7, 7, 7, 7, 1'b0, 3'b001);
    wait_done(3'b001, "pt77", 1, 1);
    chk("pt77_hit_cycle", 64'(last_hit_cyc - c0), 64'd4);

    launch(2045, 2047, 2047, 2047, 2047, 2045, 1'b0, 3'b001);
    wait_done(3'b001, "edge", 9, 6);

    launch(0, 0, 4, 0, 0, 4, 1'b1, 3'b001);
    wait_done(3'b001, "chk0", 25, 0);

    // start with new vertices while scanning must change nothing
    launch(0, 0, 4, 0, 0, 4, 1'b0, 3'b001);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_ready", 64'(ready_a), 64'd0);
    ax = 11'd10; ay = 11'd10; bx = 11'd20; by = 11'd10; cx = 11'd10; cy = 11'd20;
    start_v = 3'b001;
    @(posedge clk); #1;
    start_v = '0;
    wait_done(3'b001, "ign", 25, 15);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_no_restart", 64'(pv_a), 64'd0);

    launch(0, 0, 4, 0, 0, 4, 1'b0, 3'b001);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset("midrst");
    pq.delete();
    hq.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_flush", 64'(hv_a), 64'd0);
    end
    launch(0, 0, 4, 0, 0, 4, 1'b0, 3'b001);
    wait_done(3'b001, "postrst", 25, 15);

    launch(0, 0, 4, 0, 0, 4, 1'b0, 3'b111);
    wait_done(3'b111, "lat", 25, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
